// File: rtl/avalon_multi_timer.sv
// Multi-channel Avalon-MM interval timer: NUM_CH down-counters, each with a prescaler, snapshot and IRQ.
// Define MULTI_TIMER_PWM_EN to add a per-channel COMPARE register (offset 4) and the pwm_out port.
module avalon_multi_timer #(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 32,
  parameter int PERIOD_RST = 249999,
  localparam int ADDR_W    = $clog2(NUM_CH) + 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [NUM_CH-1:0] irq_vec,
`ifdef MULTI_TIMER_PWM_EN
  output logic [NUM_CH-1:0] pwm_out,
`endif
  output logic              irq
);

  localparam logic [CNT_W-1:0] PER_RST = CNT_W'(PERIOD_RST);

  logic [CNT_W-1:0] cnt_q  [NUM_CH];
  logic [CNT_W-1:0] cnt_d  [NUM_CH];
  logic [CNT_W-1:0] per_q  [NUM_CH];
  logic [CNT_W-1:0] per_d  [NUM_CH];
  logic [CNT_W-1:0] snap_q [NUM_CH];
  logic [CNT_W-1:0] snap_d [NUM_CH];
  logic [7:0]       psc_q  [NUM_CH];
  logic [7:0]       psc_d  [NUM_CH];
  logic [7:0]       pcnt_q [NUM_CH];
  logic [7:0]       pcnt_d [NUM_CH];
  logic [NUM_CH-1:0] run_q, run_d, to_q, to_d, ito_q, ito_d, cont_q, cont_d;
  logic [NUM_CH-1:0] ch_sel, tick;
  logic [31:0]       rdata_q, rdata_d;
`ifdef MULTI_TIMER_PWM_EN
  logic [CNT_W-1:0]  cmp_q [NUM_CH];
  logic [CNT_W-1:0]  cmp_d [NUM_CH];
  logic [NUM_CH-1:0] pwm_q, pwm_d;
`endif

  logic [ADDR_W-1:0] ch_idx;
  logic [2:0]        reg_ofs;
  logic              wr_en;

  assign ch_idx  = address >> 3;
  assign reg_ofs = address[2:0];
  assign wr_en   = chipselect & ~write_n;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_dec
    assign ch_sel[g] = wr_en && (ch_idx == ADDR_W'(g));
    assign tick[g]   = run_q[g] && (pcnt_q[g] == psc_q[g]);
  end

  always_comb begin
    cnt_d  = cnt_q;
    per_d  = per_q;
    snap_d = snap_q;
    psc_d  = psc_q;
    pcnt_d = pcnt_q;
    run_d  = run_q;
    to_d   = to_q;
    ito_d  = ito_q;
    cont_d = cont_q;
`ifdef MULTI_TIMER_PWM_EN
    cmp_d  = cmp_q;
    pwm_d  = '0;
`endif
    for (int i = 0; i < NUM_CH; i++) begin
      if (!run_q[i] || tick[i]) pcnt_d[i] = '0;
      else                      pcnt_d[i] = pcnt_q[i] + 8'd1;

      // Clear first so a coincident timeout wins over a STATUS write.
      if (ch_sel[i] && reg_ofs == 3'd0) to_d[i] = 1'b0;

      if (tick[i]) begin
        if (cnt_q[i] == '0) begin
          cnt_d[i] = per_q[i];
          if (!(ch_sel[i] && reg_ofs == 3'd2)) to_d[i] = 1'b1;
          if (!cont_q[i]) run_d[i] = 1'b0;
        end else begin
          cnt_d[i] = cnt_q[i] - CNT_W'(1);
        end
      end

      if (ch_sel[i] && reg_ofs == 3'd1) begin
        ito_d[i]  = writedata[0];
        cont_d[i] = writedata[1];
        psc_d[i]  = writedata[15:8];
        if (writedata[2]) begin
          run_d[i]  = 1'b1;
          pcnt_d[i] = '0;
        end
        if (writedata[3]) run_d[i] = 1'b0;
      end

      if (ch_sel[i] && reg_ofs == 3'd2) begin
        per_d[i]  = writedata[CNT_W-1:0];
        cnt_d[i]  = writedata[CNT_W-1:0];
        run_d[i]  = 1'b0;
        pcnt_d[i] = '0;
      end

      if (ch_sel[i] && reg_ofs == 3'd3) snap_d[i] = cnt_q[i];

`ifdef MULTI_TIMER_PWM_EN
      if (ch_sel[i] && reg_ofs == 3'd4) cmp_d[i] = writedata[CNT_W-1:0];
      pwm_d[i] = run_q[i] && (cnt_q[i] < cmp_q[i]);
`endif
    end
  end

  always_comb begin
    rdata_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_idx == ADDR_W'(i)) begin
        case (reg_ofs)
          3'd0:    rdata_d = {30'd0, run_q[i], to_q[i]};
          3'd1:    rdata_d = {16'd0, psc_q[i], 6'd0, cont_q[i], ito_q[i]};
          3'd2:    rdata_d = 32'(per_q[i]);
          3'd3:    rdata_d = 32'(snap_q[i]);
`ifdef MULTI_TIMER_PWM_EN
          3'd4:    rdata_d = 32'(cmp_q[i]);
`endif
          default: rdata_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]  <= PER_RST;
        per_q[i]  <= PER_RST;
        snap_q[i] <= '0;
        psc_q[i]  <= '0;
        pcnt_q[i] <= '0;
`ifdef MULTI_TIMER_PWM_EN
        cmp_q[i]  <= '0;
`endif
      end
      run_q   <= '0;
      to_q    <= '0;
      ito_q   <= '0;
      cont_q  <= '0;
      rdata_q <= '0;
`ifdef MULTI_TIMER_PWM_EN
      pwm_q   <= '0;
`endif
    end else begin
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      snap_q  <= snap_d;
      psc_q   <= psc_d;
      pcnt_q  <= pcnt_d;
      run_q   <= run_d;
      to_q    <= to_d;
      ito_q   <= ito_d;
      cont_q  <= cont_d;
      rdata_q <= rdata_d;
`ifdef MULTI_TIMER_PWM_EN
      cmp_q   <= cmp_d;
      pwm_q   <= pwm_d;
`endif
    end
  end

  assign readdata = rdata_q;
  assign irq_vec  = to_q & ito_q;
  assign irq      = |irq_vec;
`ifdef MULTI_TIMER_PWM_EN
  assign pwm_out  = pwm_q;
`endif

endmodule

// File: tb/tb_avalon_multi_timer.sv
// Self-checking bench for avalon_multi_timer (default parameters); read expectations go through a scoreboard queue.
module tb_avalon_multi_timer;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [ADDR_W-1:0] address = '0;
  logic              chipselect = 1'b0;
  logic              write_n = 1'b1;
  logic [31:0]       writedata = '0;
  logic [31:0]       readdata;
  logic [3:0]        irq_vec;
  logic              irq;
`ifdef MULTI_TIMER_PWM_EN
  logic [3:0]        pwm_out;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];
  logic [31:0] got, e;
  logic [31:0] m_status[3], m_ctrl[3], m_per[3];

  always #5 clk = ~clk;

  avalon_multi_timer dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq_vec    (irq_vec),
`ifdef MULTI_TIMER_PWM_EN
    .pwm_out    (pwm_out),
`endif
    .irq        (irq)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int ch, input int ofs, input logic [31:0] d);
    address    = ADDR_W'((ch << 3) | ofs);
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  // Returns the register value as it stood when the address was presented.
  task automatic rd(input int ch, input int ofs, input logic [31:0] exp, output logic [31:0] r);
    address    = ADDR_W'((ch << 3) | ofs);
    chipselect = 1'b1;
    write_n    = 1'b1;
    sb.push_back(exp);
    tick();
    r          = readdata;
    chipselect = 1'b0;
  endtask

  task automatic wait_irq(input int idx, input int max, output int n);
    n = 0;
    while (irq_vec[idx] !== 1'b1 && n < max) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    reset = 1'b0;
    tick();
    checks++; if (readdata !== 32'd0) begin errors++; $display("FAIL reset_readdata got=%0h exp=0", readdata); end
    checks++; if (irq !== 1'b0 || irq_vec !== 4'd0) begin errors++; $display("FAIL reset_irq got=%b/%b exp=0/0000", irq, irq_vec); end
    rd(0, 2, 32'd249999, got); e = sb.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL reset_ch0_period got=%0d exp=%0d", got, e); end
    rd(0, 0, 32'd0, got); e = sb.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL reset_ch0_status got=%0h exp=%0h", got, e); end
    rd(0, 1, 32'd0, got); e = sb.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL reset_ch0_control got=%0h exp=%0h", got, e); end
    rd(3, 2, 32'd249999, got); e = sb.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL reset_ch3_period got=%0d exp=%0d", got, e); end
    rd(0, 3, 32'd0, got); e = sb.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL reset_ch0_snap got=%0h exp=%0h", got, e); end
  endtask

  task automatic test_continuous();
    int n;
    wr(1, 2, 32'd9);
    wr(1, 1, 32'h0007);
    wait_irq(1, 40, n);
    checks++; if (n != 10) begin errors++; $display("FAIL cont_first_timeout got=%0d clocks exp=10", n); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL cont_irq_or got=%b exp=1", irq); end
    wr(1, 0, 32'd0);
    checks++; if (irq_vec[1] !== 1'b0) begin errors++; $display("FAIL cont_status_clear got=%b exp=0", irq_vec[1]); end
    wait_irq(1, 40, n);
    checks++; if (n != 9) begin errors++; $display("FAIL cont_repeat_timeout got=%0d clocks exp=9", n); end
    wr(1, 1, 32'h000B);
    wr(1, 0, 32'd0);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL cont_after_stop_irq got=%b exp=0", irq); end
    m_ctrl[1] = 32'h0003; m_per[1] = 32'd9; m_status[1] = 32'd0;
  endtask

  task automatic test_one_shot();
    int n;
    wr(2, 2, 32'd4);
    wr(2, 1, 32'h0305);
    wait_irq(2, 60, n);
    checks++; if (n != 20) begin errors++; $display("FAIL oneshot_timeout got=%0d clocks exp=20", n); end
    rd(2, 0, 32'h1, got); e = sb.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL oneshot_status got=%0h exp=%0h", got, e); end
    wr(2, 3, 32'd0);
    rd(2, 3, 32'd4, got); e = sb.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL oneshot_counter_hold got=%0d exp=%0d", got, e); end
    wr(2, 0, 32'd0);
    repeat (30) tick();
    checks++; if (irq_vec[2] !== 1'b0) begin errors++; $display("FAIL oneshot_no_retrigger got=%b exp=0", irq_vec[2]); end
    rd(2, 0, 32'h0, got); e = sb.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL oneshot_status_cleared got=%0h exp=%0h", got, e); end
    m_ctrl[2] = 32'h0301; m_per[2] = 32'd4; m_status[2] = 32'd0;
  endtask

  task automatic test_snap_period();
    wr(0, 2, 32'd100);
    wr(0, 1, 32'h0004);
    repeat (5) tick();
    wr(0, 3, 32'd0);
    rd(0, 3, 32'd95, got); e = sb.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL snap_value got=%0d exp=%0d", got, e); end
    wr(0, 2, 32'd50);
    rd(0, 0, 32'h0, got); e = sb.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL period_write_stops got=%0h exp=%0h", got, e); end
    repeat (5) tick();
    wr(0, 3, 32'd0);
    rd(0, 3, 32'd50, got); e = sb.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL period_reload got=%0d exp=%0d", got, e); end
    // PERIOD write landing exactly on the timeout edge must not set TO.
    wr(0, 2, 32'd3);
    wr(0, 1, 32'h0007);
    repeat (3) tick();
    wr(0, 2, 32'd3);
    checks++; if (irq_vec[0] !== 1'b0) begin errors++; $display("FAIL period_vs_timeout_irq got=%b exp=0", irq_vec[0]); end
    rd(0, 0, 32'h0, got); e = sb.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL period_vs_timeout_status got=%0h exp=%0h", got, e); end
  endtask

  task automatic test_collisions();
    int n;
    wr(0, 1, 32'h0007);
    repeat (3) tick();
    wr(0, 0, 32'd0);
    checks++; if (irq_vec[0] !== 1'b1) begin errors++; $display("FAIL status_vs_timeout_irq got=%b exp=1", irq_vec[0]); end
    rd(0, 0, 32'h3, got); e = sb.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL status_vs_timeout_status got=%0h exp=%0h", got, e); end
    wr(0, 1, 32'h050F);
    wr(0, 0, 32'd0);
    rd(0, 0, 32'h0, got); e = sb.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL start_stop_run got=%0h exp=%0h", got, e); end
    rd(0, 1, 32'h0503, got); e = sb.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL control_readback got=%0h exp=%0h", got, e); end
    wr(0, 2, 32'd77);
    m_ctrl[0] = 32'h0503; m_per[0] = 32'd77; m_status[0] = 32'd0;
    wr(3, 2, 32'd2);
    wr(3, 1, 32'h0005);
    wait_irq(3, 30, n);
    checks++; if (n != 3) begin errors++; $display("FAIL ch3_timeout got=%0d clocks exp=3", n); end
    checks++; if (irq_vec !== 4'b1000) begin errors++; $display("FAIL ch3_irq_vec got=%b exp=1000", irq_vec); end
    for (int c = 0; c < 3; c++) begin
      for (int o = 0; o < 3; o++) begin
        rd(c, o, (o == 0) ? m_status[c] : (o == 1) ? m_ctrl[c] : m_per[c], got);
        e = sb.pop_front();
        checks++; if (got !== e) begin errors++; $display("FAIL isolation_ch%0d_ofs%0d got=%0h exp=%0h", c, o, got, e); end
      end
    end
  endtask

  task automatic test_unmapped();
    wr(1, 5, 32'hFFFF_FFFF);
    rd(1, 5, 32'd0, got); e = sb.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL offset5_read got=%0h exp=%0h", got, e); end
    rd(1, 2, 32'd9, got); e = sb.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL offset5_no_side_effect got=%0d exp=%0d", got, e); end
  endtask

  task automatic test_compare();
`ifdef MULTI_TIMER_PWM_EN
    int hi;
    wr(0, 2, 32'd9);
    wr(0, 4, 32'd3);
    wr(0, 1, 32'h0006);
    rd(0, 4, 32'd3, got); e = sb.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL compare_readback got=%0d exp=%0d", got, e); end
    repeat (12) tick();
    hi = 0;
    for (int k = 0; k < 20; k++) begin
      if (pwm_out[0] === 1'b1) hi++;
      tick();
    end
    checks++; if (hi != 6) begin errors++; $display("FAIL pwm_duty got=%0d high of 20 exp=6", hi); end
`else
    wr(0, 4, 32'd5);
    rd(0, 4, 32'd0, got); e = sb.pop_front();
    checks++; if (got !== e) begin errors++; $display("FAIL compare_absent got=%0h exp=%0h", got, e); end
`endif
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_one_shot();
    test_snap_period();
    test_collisions();
    test_unmapped();
    test_compare();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/avalon_multi_timer.md
Name: avalon_multi_timer

Overview:
- Parametrised multi-channel interval timer with one Avalon-MM slave port. It is the successor to the single-channel 16-bit-bus system timer.
- Provides NUM_CH independent down-counters of CNT_W bits. Each channel has a per-channel clock prescaler, snapshot, one-shot/continuous mode and interrupt enable.
- Exposes a per-channel IRQ vector and an OR-reduced IRQ to the Nios/Qsys interconnect.

Parameters:
- NUM_CH, 4, number of timer channels (1..8).
- CNT_W, 32, counter/period width in bits (8..32).
- PERIOD_RST, 249999, reset value of every period register and counter (truncated to CNT_W).
- ADDR_W, clog2(NUM_CH)+3, word address width. Derived; not to be overridden.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-high reset.
- address  in  ADDR_W  word address; [ADDR_W-1:3] = channel, [2:0] = register.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe, qualified by chipselect.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- irq_vec  out  NUM_CH  per-channel interrupt, level.
- irq  out  1  OR of irq_vec.
- pwm_out  out  NUM_CH  compare output. Present only with MULTI_TIMER_PWM_EN.

Behaviour:
- Reset is asynchronous and active-high; one clock, clk.
- Register map per channel (word offset):
  - 0 STATUS: bit0 TO, bit1 RUN. Any write clears TO.
  - 1 CONTROL: bit0 ITO, bit1 CONT, bit2 START (write-only pulse), bit3 STOP (write-only pulse), bits[15:8] PRESC. Bits [1:0] and [15:8] are stored; bits [3:2] read 0.
  - 2 PERIOD: CNT_W bits, zero-extended on read.
  - 3 SNAP: any write latches the counter value; a read returns the latched value.
  - 4 COMPARE: present only with PWM_EN.
  - Offsets 5..7, nonexistent channels, and COMPARE without PWM_EN read 0; writes to them are ignored.
- readdata is registered every cycle from address: 1-cycle latency, no wait states. Reset value 0.
- Reset values:
  - counter = period = PERIOD_RST.
  - RUN, TO, ITO, CONT = 0; PRESC = 0; snapshot = 0; compare = 0.
  - irq_vec = 0, irq = 0, pwm_out = 0.
- Prescaler: a per-channel 8-bit counter produces tick every PRESC+1 clocks while RUN=1. It is cleared to 0 on START, on a PERIOD write, and while RUN=0.
- Counting: while RUN=1 and tick is high:
  - If counter != 0, counter decrements by 1.
  - If counter == 0, counter reloads PERIOD and TO is set (timeout). If CONT=0, RUN clears in the same cycle.
  - Timeout period = (PERIOD+1)*(PRESC+1) clocks.
- PERIOD write: the register updates, the counter loads the new value on the next clock, and RUN clears. It does not set TO, even if a timeout would occur in the same cycle.
- START sets RUN and STOP clears RUN. START and STOP in the same write: STOP wins. START while already running restarts the prescaler; the counter is untouched.
- A STATUS write and a timeout in the same cycle: TO ends at 1 (the set wins).
- irq_vec[ch] = TO & ITO (combinational from the registers). Clearing ITO deasserts the IRQ but leaves TO intact.
- PERIOD = 0 with CONT=1 and PRESC=0: TO is set on every clock.
- Channels are fully independent. Accesses to one channel never alter another.

Optional Feature:
- Macro: MULTI_TIMER_PWM_EN.
- Defined:
  - The per-channel COMPARE register (CNT_W bits, reset 0) exists at offset 4.
  - pwm_out[ch] is registered: high while RUN=1 and counter < COMPARE, else low.
  - COMPARE > PERIOD gives a constant high while running.
- Undefined: the pwm_out port and COMPARE logic are absent; offset 4 reads 0 and ignores writes.

Test Plan:
- Reset, then read ch0 PERIOD and STATUS -> readdata = 249999 and 0 one cycle after address is presented; irq = 0.
- ch1: PERIOD=9, CONTROL=0x0007 (ITO, CONT, START) -> TO/irq_vec[1] rise 10 clocks after START takes effect and repeat every 10 clocks until a STATUS write. The STATUS write clears irq for exactly the cycles until the next timeout.
- ch2: PERIOD=4, PRESC=3, CONT=0, START -> a single timeout after 20 clocks, then RUN=0 and the counter holds 4. No further TO after clearing.
- ch0 running: write SNAP at a known cycle -> SNAP read equals the counter value at that edge. A PERIOD write mid-count clears RUN and reloads without setting TO.
- Collisions: a STATUS write coincident with a timeout leaves TO=1. CONTROL=0x000C (START|STOP) leaves RUN=0. A ch3 timeout leaves ch0..ch2 state unchanged.
- With MULTI_TIMER_PWM_EN: PERIOD=9, COMPARE=3, CONT, START -> pwm_out[0] high 3 of every 10 clocks. Without the macro, a COMPARE read returns 0.
